universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised universal shift register: the next generation of the team's 8-bit serial-in/parallel-out shifter. It adds width generalisation, parallel load, bidirectional shift, rotate and arithmetic shift, and a counted burst engine with busy/done handshake. It sits between parallel datapath registers and serial links, acting as serializer, deserializer or barrel-style rotator.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CW, $clog2(WIDTH+1), width of shift_count (derived, not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  single-step enable (IDLE only)
- mode  in  3  operation select (encoding below)
- load_data  in  WIDTH  parallel load value
- ser_in_msb  in  1  serial bit entering MSB on right shift
- ser_in_lsb  in  1  serial bit entering LSB on left shift
- start  in  1  begin counted burst using current mode
- shift_count  in  CW  number of shifts in burst
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-complete pulse
- par_out  out  WIDTH  register contents
- ser_out_lsb  out  1  par_out[0]
- ser_out_msb  out  1  par_out[WIDTH-1]

## Operation
- Mode encoding: 0 HOLD, 1 LOAD, 2 SHR (MSB←ser_in_msb, toward LSB), 3 SHL (LSB←ser_in_lsb), 4 ROTR (MSB←old bit 0), 5 ROTL (LSB←old MSB), 6 ASR (MSB replicated), 7 reserved, behaves as HOLD.
- FSM states IDLE, SHIFT, DONE.
- IDLE: start=1 with mode in 2..6 latches mode and shift_count, no data change, goes to SHIFT. Otherwise, en=1 applies mode once; en=0 holds. start takes priority over en.
- start with mode 0, 1 or 7 is ignored; en still applies if asserted.
- SHIFT: if remaining count is 0, go to DONE without changing data; otherwise apply latched mode once and decrement. Serial inputs are sampled live each shift edge. en, mode, start and load_data are ignored.
- DONE: one cycle, then IDLE. en and start are ignored.
- shift_count is not clamped. Counts > WIDTH are legal: shifts flush to serial-in data, and rotates wrap modulo WIDTH.
- busy = (state==SHIFT); done = (state==DONE).

## Timing
- Reset (asynchronous, any time, including mid-burst): par_out=0, state IDLE, busy=0, done=0, internal count=0.
- Single-step: result visible on par_out after the sampling edge (1-cycle latency).
- Burst: start sampled at edge k. Shifts occur at edges k+1..k+N. busy is high from edge k to edge k+N+1. done is high for the single cycle following edge k+N+1.
- N=0: busy for one cycle, then done, with data unchanged.
- Back-to-back bursts: earliest next start is sampled in the first IDLE cycle after done, giving a minimum 2-cycle gap of busy low between bursts.
- ser_out_* are combinational from the register (no extra latency).

## Structure
- Package usr_pkg: mode enum usr_mode_t (3 bits, values above) and state enum usr_state_t.
- Sub-module usr_bit_cell: one bit, consisting of a next-value mux (hold/load/left neighbour/right neighbour) plus an async-reset flop.
- The top level generates WIDTH cells, MSB/LSB boundary muxing (serial in, rotate, ASR), the FSM and the down-counter.

## Test plan
- Reset mid-burst: load 0xA5, start SHR N=5, assert rst_n=0 after 2 shifts -> par_out=0, busy=0 immediately, FSM in IDLE.
- Single-step: LOAD 0x81, then en=1 SHL with ser_in_lsb=1 -> 0x03; then ROTR -> 0x81; then ASR -> 0xC0.
- Deserialize: WIDTH=8, start SHR N=8 with ser_in_msb driven 1,0,1,1,0,0,1,0 -> par_out=0x4D. busy high for 9 cycles, done pulses once, data stable afterwards.
- Rotate wrap: LOAD 0x12, start ROTL N=12 -> par_out=0x21. Same with N=8 -> 0x12.
- Edge/ignore: start with mode LOAD -> no busy; start N=0 -> busy 1 cycle, then done, data unchanged; start and en toggled during SHIFT -> no effect.
- WIDTH=13 instance: LOAD 0x1FFF, ASR N=3 -> 0x1FFF; SHR N=13 with ser_in_msb=0 -> 0x0000.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes, FSM states and
// the per-bit next-value select.
package usr_pkg;

  typedef enum logic [2:0] {
    ModeHold = 3'd0,
    ModeLoad = 3'd1,
    ModeShr  = 3'd2,
    ModeShl  = 3'd3,
    ModeRotr = 3'd4,
    ModeRotl = 3'd5,
    ModeAsr  = 3'd6,
    ModeRsvd = 3'd7
  } usr_mode_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } usr_state_t;

  // Source of each bit's next value; "high"/"low" are the neighbours at i+1 / i-1.
  typedef enum logic [1:0] {
    SelHold     = 2'd0,
    SelLoad     = 2'd1,
    SelFromHigh = 2'd2,
    SelFromLow  = 2'd3
  } usr_sel_t;

  // Only shifting/rotating modes can start a counted burst.
  function automatic logic is_burst_mode(usr_mode_t m);
    return (m >= ModeShr) && (m <= ModeAsr);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register. master drives the
// controls, slave is the register itself.
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic             ser_in_msb;
  logic             ser_in_lsb;
  logic             start;
  logic [CW-1:0]    shift_count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] par_out;
  logic             ser_out_lsb;
  logic             ser_out_msb;

  modport master (
    output en, mode, load_data, ser_in_msb, ser_in_lsb, start, shift_count,
    input  busy, done, par_out, ser_out_lsb, ser_out_msb
  );

  modport slave (
    input  en, mode, load_data, ser_in_msb, ser_in_lsb, start, shift_count,
    output busy, done, par_out, ser_out_lsb, ser_out_msb
  );
endinterface

// File: rtl/usr_bit_cell.sv
// One register bit: next-value mux (hold/load/neighbour above/neighbour below)
// feeding an async-reset flop.
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  usr_sel_t sel,
  input  logic     load_bit,
  input  logic     from_high,
  input  logic     from_low,
  output logic     q
);

  logic d;

  // Select the bit's next value.
  always_comb begin
    d = q;
    unique case (sel)
      SelHold:     d = q;
      SelLoad:     d = load_bit;
      SelFromHigh: d = from_high;
      SelFromLow:  d = from_low;
      default:     d = q;
    endcase
  end

  // Bit storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: WIDTH bit cells, boundary muxing for serial-in,
// rotate and arithmetic shift, plus an IDLE/SHIFT/DONE burst engine with a
// down-counter.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input logic                       clk,
  input logic                       rst_n,
  universal_shift_register_if.slave bus
);

  usr_state_t       state_q, state_d;
  usr_mode_t        mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  usr_mode_t        mode_in;
  usr_mode_t        op;       // operation applied at the coming edge
  usr_sel_t         sel;
  logic             msb_in;   // value entering the MSB on a rightward move
  logic             lsb_in;   // value entering the LSB on a leftward move
  logic [WIDTH-1:0] q;

  assign mode_in = usr_mode_t'(bus.mode);

  // Next state, burst bookkeeping and choice of operation for this cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    op      = ModeHold;
    unique case (state_q)
      StIdle: begin
        // start wins over en, but only for modes that can burst.
        if (bus.start && is_burst_mode(mode_in)) begin
          state_d = StShift;
          mode_d  = mode_in;
          cnt_d   = bus.shift_count;
        end else if (bus.en) begin
          op = mode_in;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          op    = mode_q;
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state, latched burst mode and remaining count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeHold;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decode the operation into a per-bit select and the boundary inputs.
  always_comb begin
    sel    = SelHold;
    msb_in = 1'b0;
    lsb_in = 1'b0;
    unique case (op)
      ModeLoad: sel = SelLoad;
      ModeShr: begin
        sel    = SelFromHigh;
        msb_in = bus.ser_in_msb;
      end
      ModeShl: begin
        sel    = SelFromLow;
        lsb_in = bus.ser_in_lsb;
      end
      ModeRotr: begin
        sel    = SelFromHigh;
        msb_in = q[0];
      end
      ModeRotl: begin
        sel    = SelFromLow;
        lsb_in = q[WIDTH-1];
      end
      ModeAsr: begin
        sel    = SelFromHigh;
        msb_in = q[WIDTH-1];
      end
      default: sel = SelHold;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic from_high;
    logic from_low;

    if (i == WIDTH - 1) begin : g_msb
      assign from_high = msb_in;
    end else begin : g_hi
      assign from_high = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign from_low = lsb_in;
    end else begin : g_lo
      assign from_low = q[i-1];
    end

    usr_bit_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel),
      .load_bit  (bus.load_data[i]),
      .from_high (from_high),
      .from_low  (from_low),
      .q         (q[i])
    );
  end

  assign bus.par_out     = q;
  assign bus.ser_out_lsb = q[0];
  assign bus.ser_out_msb = q[WIDTH-1];
  assign bus.busy        = (state_q == StShift);
  assign bus.done        = (state_q == StDone);

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: WIDTH=8 and WIDTH=13 instances, a vector
// table of single steps, directed burst sequences and a randomized run against a
// transaction-level reference model.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(8))  bus8 ();
  universal_shift_register_if #(.WIDTH(13)) bus13 ();

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  universal_shift_register #(.WIDTH(13)) u_dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus13)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic       sm;
    logic       sl;
    logic [7:0] ld;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];
  logic des_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  // Reference model state, index 0 = WIDTH 8, index 1 = WIDTH 13.
  int          wid[2] = '{8, 13};
  logic [63:0] m_val[2];
  int          m_busy_left[2];
  bit          m_done[2];
  int          m_mode[2];

  logic        st_en[2];
  logic [2:0]  st_mode[2];
  logic        st_start[2];
  logic [3:0]  st_cnt[2];
  logic        st_sm[2];
  logic        st_sl[2];
  logic [12:0] st_ld[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] par_of(input int i);
    if (i == 0) return {56'd0, bus8.par_out};
    return {51'd0, bus13.par_out};
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? bus8.busy : bus13.busy;
  endfunction

  function automatic logic done_of(input int i);
    return (i == 0) ? bus8.done : bus13.done;
  endfunction

  function automatic logic [1:0] sout_of(input int i);
    if (i == 0) return {bus8.ser_out_msb, bus8.ser_out_lsb};
    return {bus13.ser_out_msb, bus13.ser_out_lsb};
  endfunction

  task automatic drive(input int i, input logic e, input logic [2:0] m, input logic s,
                       input logic [3:0] n, input logic sm, input logic sl,
                       input logic [12:0] ld);
    if (i == 0) begin
      bus8.en = e; bus8.mode = m; bus8.start = s; bus8.shift_count = n;
      bus8.ser_in_msb = sm; bus8.ser_in_lsb = sl; bus8.load_data = ld[7:0];
    end else begin
      bus13.en = e; bus13.mode = m; bus13.start = s; bus13.shift_count = n;
      bus13.ser_in_msb = sm; bus13.ser_in_lsb = sl; bus13.load_data = ld;
    end
  endtask

  // Drive on the falling edge, observe just after the next rising edge.
  task automatic cyc(input int i, input logic e, input logic [2:0] m, input logic s,
                     input logic [3:0] n, input logic sm, input logic sl,
                     input logic [12:0] ld);
    @(negedge clk);
    drive(i, e, m, s, n, sm, sl, ld);
    @(posedge clk);
    #1;
  endtask

  // Run cycles until done is seen; noise toggles en/start/mode/load to prove they are ignored.
  task automatic wait_done(input int i, input int budget, input logic noise, output int busy_seen);
    bit seen;
    seen = 1'b0;
    busy_seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (noise) cyc(i, 1'b1, ModeShr, 1'b1, 4'd15, 1'b1, 1'b0, 13'h1FFF);
      else       cyc(i, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);
      if (busy_of(i)) busy_seen++;
      if (done_of(i)) seen = 1'b1;
    end
    check("burst_done_seen", {63'd0, seen}, 64'd1);
  endtask

  function automatic logic [63:0] ref_apply(input int m, input logic [63:0] v, input int w,
                                            input logic sm, input logic sl,
                                            input logic [63:0] ld);
    logic [63:0] mask, msb, r;
    mask = (64'd1 << w) - 64'd1;
    msb  = (v >> (w - 1)) & 64'd1;
    case (m)
      1:       r = ld;
      2:       r = (v >> 1) | ({63'd0, sm} << (w - 1));
      3:       r = (v << 1) | {63'd0, sl};
      4:       r = (v >> 1) | ((v & 64'd1) << (w - 1));
      5:       r = (v << 1) | msb;
      6:       r = (v >> 1) | (msb << (w - 1));
      default: r = v;
    endcase
    return r & mask;
  endfunction

  // Advance the model by one clock edge using the stimulus of instance i.
  task automatic model_step(input int i);
    if (m_busy_left[i] > 0) begin
      if (m_busy_left[i] > 1)
        m_val[i] = ref_apply(m_mode[i], m_val[i], wid[i], st_sm[i], st_sl[i], 64'd0);
      m_busy_left[i]--;
      if (m_busy_left[i] == 0) m_done[i] = 1'b1;
    end else if (m_done[i]) begin
      m_done[i] = 1'b0;
    end else if (st_start[i] && st_mode[i] >= 3'd2 && st_mode[i] <= 3'd6) begin
      m_busy_left[i] = int'(st_cnt[i]) + 1;
      m_mode[i] = int'(st_mode[i]);
    end else if (st_en[i]) begin
      m_val[i] = ref_apply(int'(st_mode[i]), m_val[i], wid[i], st_sm[i], st_sl[i],
                           {51'd0, st_ld[i]} & ((64'd1 << wid[i]) - 64'd1));
    end
  endtask

  initial begin
    int bc, dc;
    logic [63:0] exp_sout;

    vecs[0]  = '{1'b1, ModeLoad, 1'b0, 1'b0, 8'h81, 8'h81};
    vecs[1]  = '{1'b1, ModeShl,  1'b0, 1'b1, 8'h00, 8'h03};
    vecs[2]  = '{1'b1, ModeRotr, 1'b0, 1'b0, 8'h00, 8'h81};
    vecs[3]  = '{1'b1, ModeAsr,  1'b0, 1'b0, 8'h00, 8'hC0};
    vecs[4]  = '{1'b1, ModeHold, 1'b1, 1'b1, 8'hFF, 8'hC0};
    vecs[5]  = '{1'b1, ModeRsvd, 1'b1, 1'b1, 8'hFF, 8'hC0};
    vecs[6]  = '{1'b0, ModeShr,  1'b1, 1'b1, 8'hFF, 8'hC0};
    vecs[7]  = '{1'b1, ModeShr,  1'b1, 1'b0, 8'h00, 8'hE0};
    vecs[8]  = '{1'b1, ModeRotl, 1'b0, 1'b0, 8'h00, 8'hC1};
    vecs[9]  = '{1'b1, ModeLoad, 1'b0, 1'b0, 8'h5A, 8'h5A};
    vecs[10] = '{1'b1, ModeShl,  1'b0, 1'b0, 8'h00, 8'hB4};
    vecs[11] = '{1'b1, ModeShr,  1'b0, 1'b0, 8'h00, 8'h5A};

    drive(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);
    drive(1, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_par", par_of(i), 64'd0);
      check("reset_busy", {63'd0, busy_of(i)}, 64'd0);
      check("reset_done", {63'd0, done_of(i)}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single-step vector table on the 8-bit instance.
    for (int k = 0; k < 12; k++) begin
      cyc(0, vecs[k].en, vecs[k].mode, 1'b0, 4'd0, vecs[k].sm, vecs[k].sl, {5'd0, vecs[k].ld});
      check($sformatf("vec%0d_par", k), par_of(0), {56'd0, vecs[k].exp});
      exp_sout = {62'd0, vecs[k].exp[7], vecs[k].exp[0]};
      check($sformatf("vec%0d_sout", k), {62'd0, sout_of(0)}, exp_sout);
    end

    // Deserialize eight bits through the MSB.
    cyc(0, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'hFF);
    cyc(0, 1'b0, ModeShr, 1'b1, 4'd8, 1'b0, 1'b0, 13'h0);
    bc = busy_of(0) ? 1 : 0;
    dc = 0;
    for (int b = 0; b < 8; b++) begin
      cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, des_bits[b], 1'b0, 13'h0);
      bc += busy_of(0) ? 1 : 0;
      dc += done_of(0) ? 1 : 0;
    end
    for (int c = 0; c < 6; c++) begin
      cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b1, 1'b1, 13'h0);
      bc += busy_of(0) ? 1 : 0;
      dc += done_of(0) ? 1 : 0;
    end
    check("deser_par", par_of(0), 64'h4D);
    check("deser_busy_cycles", 64'(bc), 64'd9);
    check("deser_done_pulses", 64'(dc), 64'd1);

    // Rotate wrap: 12 rotations equal 4, 8 rotations equal none.
    cyc(0, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'h12);
    cyc(0, 1'b0, ModeRotl, 1'b1, 4'd12, 1'b0, 1'b0, 13'h0);
    wait_done(0, 30, 1'b0, bc);
    check("rotl12_par", par_of(0), 64'h21);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);
    cyc(0, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'h12);
    cyc(0, 1'b0, ModeRotl, 1'b1, 4'd8, 1'b0, 1'b0, 13'h0);
    wait_done(0, 30, 1'b0, bc);
    check("rotl8_par", par_of(0), 64'h12);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);

    // start with LOAD does not burst; en alone still applies.
    cyc(0, 1'b0, ModeLoad, 1'b1, 4'd3, 1'b0, 1'b0, 13'h77);
    check("start_load_nobusy", {63'd0, busy_of(0)}, 64'd0);
    check("start_load_nochange", par_of(0), 64'h12);
    cyc(0, 1'b1, ModeLoad, 1'b1, 4'd3, 1'b0, 1'b0, 13'h77);
    check("start_load_en_busy", {63'd0, busy_of(0)}, 64'd0);
    check("start_load_en_par", par_of(0), 64'h77);

    // Zero-length burst.
    cyc(0, 1'b0, ModeShr, 1'b1, 4'd0, 1'b1, 1'b1, 13'h0);
    check("n0_busy", {63'd0, busy_of(0)}, 64'd1);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b1, 1'b1, 13'h0);
    check("n0_done", {63'd0, done_of(0)}, 64'd1);
    check("n0_busy_low", {63'd0, busy_of(0)}, 64'd0);
    check("n0_par", par_of(0), 64'h77);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);
    check("n0_done_once", {63'd0, done_of(0)}, 64'd0);

    // Controls toggled during SHIFT and DONE are ignored.
    cyc(0, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'h3C);
    cyc(0, 1'b0, ModeShl, 1'b1, 4'd2, 1'b0, 1'b0, 13'h0);
    wait_done(0, 20, 1'b1, bc);
    check("noise_busy_cycles", 64'(bc), 64'd2);
    check("noise_par", par_of(0), 64'hF0);
    cyc(0, 1'b1, ModeShr, 1'b1, 4'd15, 1'b1, 1'b0, 13'h1FFF);
    check("done_ignore_busy", {63'd0, busy_of(0)}, 64'd0);
    check("done_ignore_par", par_of(0), 64'hF0);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);

    // Asynchronous reset in the middle of a burst.
    cyc(0, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'hA5);
    cyc(0, 1'b0, ModeShr, 1'b1, 4'd5, 1'b0, 1'b0, 13'h0);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b1, 1'b0, 13'h0);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b1, 1'b0, 13'h0);
    check("midburst_pre_par", par_of(0), 64'hE9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midburst_rst_par", par_of(0), 64'd0);
    check("midburst_rst_busy", {63'd0, busy_of(0)}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'h3C);
    check("post_rst_idle_load", par_of(0), 64'h3C);
    check("post_rst_busy", {63'd0, busy_of(0)}, 64'd0);
    check("post_rst_done", {63'd0, done_of(0)}, 64'd0);
    cyc(0, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);

    // 13-bit instance.
    cyc(1, 1'b1, ModeLoad, 1'b0, 4'd0, 1'b0, 1'b0, 13'h1FFF);
    check("w13_load", par_of(1), 64'h1FFF);
    cyc(1, 1'b0, ModeAsr, 1'b1, 4'd3, 1'b0, 1'b0, 13'h0);
    wait_done(1, 20, 1'b0, bc);
    check("w13_asr3", par_of(1), 64'h1FFF);
    cyc(1, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);
    cyc(1, 1'b0, ModeShr, 1'b1, 4'd13, 1'b0, 1'b0, 13'h0);
    wait_done(1, 30, 1'b0, bc);
    check("w13_shr13_busy_cycles", 64'(bc), 64'd13);
    check("w13_shr13", par_of(1), 64'h0);
    cyc(1, 1'b0, ModeHold, 1'b0, 4'd0, 1'b0, 1'b0, 13'h0);

    // Randomized run on both instances against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 64'd0;
      m_busy_left[i] = 0;
      m_done[i] = 1'b0;
      m_mode[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st_en[i]    = ($urandom_range(0, 1) == 1);
        st_mode[i]  = 3'($urandom_range(0, 7));
        st_start[i] = ($urandom_range(0, 5) == 0);
        st_cnt[i]   = 4'($urandom_range(0, 15));
        st_sm[i]    = 1'($urandom_range(0, 1));
        st_sl[i]    = 1'($urandom_range(0, 1));
        st_ld[i]    = 13'($urandom);
        drive(i, st_en[i], st_mode[i], st_start[i], st_cnt[i], st_sm[i], st_sl[i], st_ld[i]);
        model_step(i);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rand_w%0d_par", wid[i]), par_of(i), m_val[i]);
        check($sformatf("rand_w%0d_busy", wid[i]), {63'd0, busy_of(i)},
              {63'd0, m_busy_left[i] > 0});
        check($sformatf("rand_w%0d_done", wid[i]), {63'd0, done_of(i)}, {63'd0, m_done[i]});
        check($sformatf("rand_w%0d_sout", wid[i]), {62'd0, sout_of(i)},
              {62'd0, m_val[i][wid[i]-1], m_val[i][0]});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
